// File: rtl/fixed_adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: level count, per-level lane count and width,
// and the clamp used by the top when FIXED_ADDER_TREE_SAT_EN narrows with saturation.
package fixed_adder_tree_pkg;

  localparam int SAT_W = 64;

  function automatic int tree_levels(input int size);
    int lv;
    lv = $clog2(size);
    return (lv < 1) ? 1 : lv;
  endfunction

  function automatic int level_size(input int size, input int k);
    int n;
    n = size;
    for (int i = 0; i < k; i++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  function automatic int level_width(input int w, input int k);
    return w + k;
  endfunction

  // value arrives already sign/zero-extended to SAT_W; result is meaningful in its low out_w bits
  function automatic logic [SAT_W-1:0] sat_clamp(input logic [SAT_W-1:0] value,
                                                 input bit is_signed, input int out_w);
    logic signed [SAT_W-1:0] sval;
    logic signed [SAT_W-1:0] smax;
    logic signed [SAT_W-1:0] smin;
    logic [SAT_W-1:0] umax;
    sval = $signed(value);
    smax = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    smin = -smax - 64'sd1;
    umax = (64'd1 << out_w) - 64'd1;
    if (is_signed) begin
      if (sval > smax) return $unsigned(smax);
      if (sval < smin) return $unsigned(smin);
      return value;
    end
    if (value > umax) return umax;
    return value;
  endfunction

endpackage

// File: rtl/fixed_adder_tree_stage.sv
// One registered level of the adder tree: adds lane pairs (odd leftover is only extended)
// and holds the result with a valid flag behind a ready/valid handshake.
module fixed_adder_tree_stage
  import fixed_adder_tree_pkg::*;
#(
  parameter int IN_SIZE  = 8,
  parameter int IN_WIDTH = 16,
  parameter int SIGNED   = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [IN_SIZE*IN_WIDTH-1:0]                data_in,
  input  logic                                       data_in_valid,
  output logic                                       data_in_ready,
  output logic [((IN_SIZE+1)/2)*(IN_WIDTH+1)-1:0]    data_out,
  output logic                                       data_out_valid,
  input  logic                                       data_out_ready
);

  localparam int OUT_SIZE = level_size(IN_SIZE, 1);
  localparam int OUT_W    = level_width(IN_WIDTH, 1);

  logic [IN_SIZE*OUT_W-1:0]  ext_lanes;
  logic [OUT_SIZE*OUT_W-1:0] sum_next;
  logic [OUT_SIZE*OUT_W-1:0] data_reg;
  logic                      valid_reg;

  for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_ext
    logic [IN_WIDTH-1:0] lane;
    assign lane = data_in[gi*IN_WIDTH +: IN_WIDTH];
    if (SIGNED != 0) begin : g_sext
      assign ext_lanes[gi*OUT_W +: OUT_W] = {lane[IN_WIDTH-1], lane};
    end else begin : g_zext
      assign ext_lanes[gi*OUT_W +: OUT_W] = {1'b0, lane};
    end
  end

  // One extra bit always holds the sum of two lanes exactly, in either signedness
  for (genvar gi = 0; gi < OUT_SIZE; gi++) begin : g_pair
    if (2*gi + 1 < IN_SIZE) begin : g_add
      assign sum_next[gi*OUT_W +: OUT_W] = ext_lanes[(2*gi)*OUT_W +: OUT_W]
                                         + ext_lanes[(2*gi+1)*OUT_W +: OUT_W];
    end else begin : g_pass
      assign sum_next[gi*OUT_W +: OUT_W] = ext_lanes[(2*gi)*OUT_W +: OUT_W];
    end
  end

  assign data_in_ready = !valid_reg || data_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (data_in_ready) begin
      valid_reg <= data_in_valid;
      data_reg  <= sum_next;
    end
  end

  assign data_out       = data_reg;
  assign data_out_valid = valid_reg;

endmodule

// File: rtl/fixed_adder_tree_pipelined.sv
// Fully pipelined IN_SIZE-lane reduction tree with per-level backpressure and output narrowing.
// Define FIXED_ADDER_TREE_SAT_EN to saturate (instead of wrap) when OUT_WIDTH < full precision.
module fixed_adder_tree_pipelined
  import fixed_adder_tree_pkg::*;
#(
  parameter int IN_SIZE   = 8,
  parameter int IN_WIDTH  = 16,
  parameter int SIGNED    = 1,
  parameter int OUT_WIDTH = IN_WIDTH + $clog2(IN_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IN_SIZE*IN_WIDTH-1:0] data_in,
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic [OUT_WIDTH-1:0]        data_out,
  output logic                        data_out_valid,
  input  logic                        data_out_ready
);

  localparam int LEVELS = tree_levels(IN_SIZE);
  localparam int FULL_W = level_width(IN_WIDTH, LEVELS);

  logic [FULL_W-1:0] full_sum;

  for (genvar gi = 0; gi < LEVELS; gi++) begin : g_lvl
    localparam int N_IN  = level_size(IN_SIZE, gi);
    localparam int W_IN  = level_width(IN_WIDTH, gi);
    localparam int N_OUT = level_size(IN_SIZE, gi + 1);

    logic [N_IN*W_IN-1:0]      stage_in;
    logic [N_OUT*(W_IN+1)-1:0] stage_out;
    logic                      up_valid;
    logic                      down_ready;
    logic                      stage_valid;
    logic                      stage_ready;

    if (gi == 0) begin : g_src
      assign stage_in = data_in;
      assign up_valid = data_in_valid;
    end else begin : g_src
      assign stage_in = g_lvl[gi-1].stage_out;
      assign up_valid = g_lvl[gi-1].stage_valid;
    end

    // Ready ripples back combinationally so a full pipeline still moves every cycle
    if (gi == LEVELS - 1) begin : g_sink
      assign down_ready = data_out_ready;
    end else begin : g_sink
      assign down_ready = g_lvl[gi+1].stage_ready;
    end

    fixed_adder_tree_stage #(
      .IN_SIZE (N_IN),
      .IN_WIDTH(W_IN),
      .SIGNED  (SIGNED)
    ) u_stage (
      .clk           (clk),
      .rst           (rst),
      .data_in       (stage_in),
      .data_in_valid (up_valid),
      .data_in_ready (stage_ready),
      .data_out      (stage_out),
      .data_out_valid(stage_valid),
      .data_out_ready(down_ready)
    );
  end

  assign full_sum       = g_lvl[LEVELS-1].stage_out;
  assign data_in_ready  = g_lvl[0].stage_ready;
  assign data_out_valid = g_lvl[LEVELS-1].stage_valid;

  if (OUT_WIDTH == FULL_W) begin : g_full
    assign data_out = full_sum;
  end else begin : g_narrow
`ifdef FIXED_ADDER_TREE_SAT_EN
    logic [SAT_W-1:0] wide_sum;
    if (SIGNED != 0) begin : g_sw
      assign wide_sum = SAT_W'($signed(full_sum));
    end else begin : g_uw
      assign wide_sum = SAT_W'(full_sum);
    end
    assign data_out = OUT_WIDTH'(sat_clamp(wide_sum, SIGNED != 0, OUT_WIDTH));
`else
    assign data_out = OUT_WIDTH'(full_sum);
`endif
  end

endmodule

// File: tb/tb_fixed_adder_tree_pipelined.sv
// Bench for fixed_adder_tree_pipelined: vector table over several configurations,
// random backpressure stream against an arithmetic model, and mid-stream reset.
module tb_fixed_adder_tree_pipelined;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din;
  logic         in_valid;
  logic         out_ready;

  logic        rdy_s8, rdy_u8, rdy_s5, rdy_n16, rdy_s1;
  logic        vld_s8, vld_u8, vld_s5, vld_n16, vld_s1;
  logic [18:0] out_s8, out_u8, out_s5;
  logic [15:0] out_n16, out_s1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fixed_adder_tree_pipelined #(.IN_SIZE(8), .IN_WIDTH(16), .SIGNED(1)) u_s8 (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(in_valid), .data_in_ready(rdy_s8),
    .data_out(out_s8), .data_out_valid(vld_s8), .data_out_ready(out_ready));

  fixed_adder_tree_pipelined #(.IN_SIZE(8), .IN_WIDTH(16), .SIGNED(0)) u_u8 (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(in_valid), .data_in_ready(rdy_u8),
    .data_out(out_u8), .data_out_valid(vld_u8), .data_out_ready(out_ready));

  fixed_adder_tree_pipelined #(.IN_SIZE(5), .IN_WIDTH(16), .SIGNED(1)) u_s5 (
    .clk(clk), .rst(rst), .data_in(din[79:0]), .data_in_valid(in_valid), .data_in_ready(rdy_s5),
    .data_out(out_s5), .data_out_valid(vld_s5), .data_out_ready(out_ready));

  fixed_adder_tree_pipelined #(.IN_SIZE(8), .IN_WIDTH(16), .SIGNED(1), .OUT_WIDTH(16)) u_n16 (
    .clk(clk), .rst(rst), .data_in(din), .data_in_valid(in_valid), .data_in_ready(rdy_n16),
    .data_out(out_n16), .data_out_valid(vld_n16), .data_out_ready(out_ready));

  fixed_adder_tree_pipelined #(.IN_SIZE(1), .IN_WIDTH(16), .SIGNED(1)) u_s1 (
    .clk(clk), .rst(rst), .data_in(din[15:0]), .data_in_valid(in_valid), .data_in_ready(rdy_s1),
    .data_out(out_s1), .data_out_valid(vld_s1), .data_out_ready(out_ready));

  typedef struct {
    string        name;
    logic [127:0] lanes;
    longint       exp_s8;
    longint       exp_u8;
    longint       exp_s5;
    longint       exp_n16;
    longint       exp_s1;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic [127:0] fill(input logic [15:0] v);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  // Reference: the plain integer sum of the eight signed lanes
  function automatic longint model_sum(input logic [127:0] l);
    longint s;
    s = 0;
    for (int i = 0; i < 8; i++) s += longint'($signed(l[i*16 +: 16]));
    return s;
  endfunction

  function automatic logic [127:0] rand_lanes();
    logic [127:0] r;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 5))
        0:       r[i*16 +: 16] = 16'h8000;
        1:       r[i*16 +: 16] = 16'h7FFF;
        default: r[i*16 +: 16] = 16'($urandom);
      endcase
    end
    return r;
  endfunction

  task automatic run_stream(input int n, input bit random_ready, output int cycles);
    longint       exp_q[$];
    longint       e;
    logic [127:0] cur;
    logic [18:0]  held;
    bit           stalled;
    int           sent, got, cyc;
    sent = 0; got = 0; cyc = 0; stalled = 0; held = '0;
    cur = rand_lanes();
    while (got < n && cyc < 1000) begin
      @(posedge clk); #1;
      if (stalled) begin
        check("stall_valid", longint'(vld_s8), 1);
        check("stall_data", longint'(out_s8), longint'(held));
      end
      out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = (sent < n);
      din       = cur;
      #1;
      if (out_ready) check("ready_when_out_ready", longint'(rdy_s8), 1);
      if (vld_s8 && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL stream_extra: got %0d, required no result", longint'($signed(out_s8)));
        end else begin
          e = exp_q.pop_front();
          $display("[TB] stream beat %0d: out=%0d model=%0d", got, longint'($signed(out_s8)), e);
          check("stream_sum", longint'($signed(out_s8)), e);
          got++;
        end
      end
      stalled = vld_s8 && !out_ready;
      held    = out_s8;
      if (in_valid && rdy_s8) begin
        exp_q.push_back(model_sum(cur));
        sent++;
        cur = rand_lanes();
      end
      cyc++;
    end
    check("stream_results", got, n);
    cycles = cyc;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    vec_t v;
    longint c_exp;
    logic [127:0] c_lanes;

    vecs[0] = '{"ramp", {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
                36, 36, 15, 36, 1};
`ifdef FIXED_ADDER_TREE_SAT_EN
    vecs[1] = '{"all_min", fill(16'h8000), -262144, 262144, -163840, 32768, -32768};
    vecs[3] = '{"all_max", fill(16'h7FFF), 262136, 262136, 163835, 32767, 32767};
`else
    vecs[1] = '{"all_min", fill(16'h8000), -262144, 262144, -163840, 0, -32768};
    vecs[3] = '{"all_max", fill(16'h7FFF), 262136, 262136, 163835, 65528, 32767};
`endif
    vecs[2] = '{"odd_lane", {16'd0, 16'd0, 16'd0, 16'hFFEC, 16'd4, 16'd3, 16'd2, 16'd1},
                -10, 65526, -10, 65526, 1};
    vecs[4] = '{"all_neg1", fill(16'hFFFF), -8, 524280, -5, 65528, -1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; din = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", longint'(vld_s8), 0);
    check("reset_out_data", longint'(out_s8), 0);
    check("reset_in_ready", longint'(rdy_s8), 1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      @(posedge clk); #1;
      din = v.lanes; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check({v.name, "_in_ready"}, longint'(rdy_s8), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({v.name, "_s1_valid"}, longint'(vld_s1), 1);
      check({v.name, "_s1_sum"}, longint'($signed(out_s1)), v.exp_s1);
      check({v.name, "_s8_early1"}, longint'(vld_s8), 0);
      @(posedge clk); #1;
      check({v.name, "_s8_early2"}, longint'(vld_s8), 0);
      @(posedge clk); #1;
      $display("[TB] vec %s: s8=%0d u8=%0d s5=%0d n16=%0d s1=%0d", v.name,
               longint'($signed(out_s8)), longint'(out_u8), longint'($signed(out_s5)),
               longint'(out_n16), longint'($signed(out_s1)));
      check({v.name, "_s8_valid"}, longint'(vld_s8), 1);
      check({v.name, "_s8_sum"}, longint'($signed(out_s8)), v.exp_s8);
      check({v.name, "_u8_sum"}, longint'(out_u8), v.exp_u8);
      check({v.name, "_s5_valid"}, longint'(vld_s5), 1);
      check({v.name, "_s5_sum"}, longint'($signed(out_s5)), v.exp_s5);
      check({v.name, "_n16_sum"}, longint'(out_n16), v.exp_n16);
    end

    run_stream(20, 1'b1, cyc);
    run_stream(12, 1'b0, cyc);
    check("full_rate_cycles", cyc, 15);

    // Two beats in flight, consumer blocked, then reset
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; din = rand_lanes();
    @(posedge clk); #1;
    din = rand_lanes();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_valid", longint'(vld_s8), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    $display("[TB] reset mid-stream: valid=%0d out=%0d in_ready=%0d", vld_s8, out_s8, rdy_s8);
    check("midrst_out_valid", longint'(vld_s8), 0);
    check("midrst_out_data", longint'(out_s8), 0);
    check("midrst_in_ready", longint'(rdy_s8), 1);
    rst = 1'b0;
    c_lanes = rand_lanes();
    c_exp = model_sum(c_lanes);
    out_ready = 1'b1; din = c_lanes; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("post_rst_early1", longint'(vld_s8), 0);
    @(posedge clk); #1;
    check("post_rst_early2", longint'(vld_s8), 0);
    @(posedge clk); #1;
    $display("[TB] post-reset beat: out=%0d model=%0d", longint'($signed(out_s8)), c_exp);
    check("post_rst_valid", longint'(vld_s8), 1);
    check("post_rst_sum", longint'($signed(out_s8)), c_exp);
    @(posedge clk); #1;
    check("post_rst_drained", longint'(vld_s8), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
